elastic_pipeline: RTL and testbench

ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

---
 rtl/elastic_pipeline.sv | 106 ++++++++++
 tb/tb_elastic_pipeline.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipeline.sv
// Elastic pipeline: a chain of two-slot skid-buffer stages.
// All outputs come straight from stage registers; count tracks words held.
module elastic_pipeline #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CW-1:0]    count_o
);

  logic [DEPTH-1:0] main_v;
  logic [DEPTH-1:0] skid_v;
  logic [DEPTH-1:0] in_v;
  logic [DEPTH-1:0] out_r;
  logic [WIDTH-1:0] main_d [DEPTH];
  logic [WIDTH-1:0] in_d   [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             mv;
    logic             sv;
    logic             acc;
    logic             pop;
    logic [WIDTH-1:0] md;
    logic [WIDTH-1:0] sd;

    if (i == 0) begin : g_head
      assign in_v[i] = valid_i;
      assign in_d[i] = din_i;
    end else begin : g_link
      assign in_v[i] = main_v[i-1];
      assign in_d[i] = main_d[i-1];
    end

    if (i == DEPTH-1) begin : g_tail
      assign out_r[i] = ready_i;
    end else begin : g_mid
      assign out_r[i] = ~skid_v[i+1];
    end

    // upstream ready is the registered "skid empty" flag
    assign acc = in_v[i] & ~sv;
    assign pop = mv & out_r[i];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mv <= 1'b0;
        sv <= 1'b0;
        md <= '0;
        sd <= '0;
      end else if (flush) begin
        mv <= 1'b0;
        sv <= 1'b0;
      end else if (!mv || pop) begin
        if (sv) begin
          mv <= 1'b1;
          md <= sd;
          sv <= 1'b0;
        end else begin
          mv <= acc;
          if (acc) md <= in_d[i];
        end
      end else if (acc) begin
        sv <= 1'b1;
        sd <= in_d[i];
      end
    end

    assign main_v[i] = mv;
    assign skid_v[i] = sv;
    assign main_d[i] = md;
  end

  assign ready_o = ~skid_v[0];
  assign valid_o = main_v[DEPTH-1];
  assign dout_o  = main_d[DEPTH-1];

  logic in_x;
  logic out_x;

  assign in_x  = valid_i & ready_o;
  assign out_x = valid_o & ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_o <= '0;
    end else if (flush) begin
      count_o <= '0;
    end else begin
      case ({in_x, out_x})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: tb/tb_elastic_pipeline.sv
// Bench for elastic_pipeline: queue model checked every cycle plus
// directed streaming, fill, flush, reset and DEPTH=1 scenarios.
module tb_elastic_pipeline;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] din_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] dout_o;
  logic       valid_o;
  logic       ready_i;
  logic [3:0] count_o;

  logic [7:0] d1_din;
  logic       d1_valid_i;
  logic       d1_ready_o;
  logic [7:0] d1_dout;
  logic       d1_valid_o;
  logic       d1_ready_i;
  logic [1:0] d1_count;

  always #5 clk = ~clk;

  elastic_pipeline #(.WIDTH(8), .DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .din_i   (din_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .dout_o  (dout_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .count_o (count_o)
  );

  elastic_pipeline #(.WIDTH(8), .DEPTH(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .din_i   (d1_din),
    .valid_i (d1_valid_i),
    .ready_o (d1_ready_o),
    .dout_o  (d1_dout),
    .valid_o (d1_valid_o),
    .ready_i (d1_ready_i),
    .count_o (d1_count)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO of accepted words, capacity 8.
  logic [7:0] q [$];
  int         delivered = 0;
  logic       hold_v = 1'b0;
  logic [7:0] held = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      hold_v <= 1'b0;
    end else begin
      hold_v <= valid_o && !ready_i && !flush;
      held   <= dout_o;
      if (flush) begin
        q.delete();
      end else begin
        if (valid_o && ready_i) begin
          if (q.size() > 0) void'(q.pop_front());
          delivered <= delivered + 1;
        end
        if (valid_i && ready_o) q.push_back(din_i);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("m_count", 32'(count_o), q.size());
      if (q.size() == 0) chk("m_empty_valid", 32'(valid_o), 0);
      if (valid_o && q.size() > 0) chk("m_head", 32'(dout_o), 32'(q[0]));
      if (hold_v) begin
        chk("m_hold_valid", 32'(valid_o), 1);
        chk("m_hold_data", 32'(dout_o), 32'(held));
      end
      if (q.size() == 8) chk("m_full_ready", 32'(ready_o), 0);
      if (q.size() < 2) chk("m_free_ready", 32'(ready_o), 1);
    end
  end

  initial begin
    int n;
    int got;
    int seen;
    int acc;
    int d0;

    rst = 1'b0;
    flush = 1'b0;
    din_i = '0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    d1_din = '0;
    d1_valid_i = 1'b0;
    d1_ready_i = 1'b0;

    #2;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_dout", 32'(dout_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_ready", 32'(ready_o), 1);
    chk("rst1_ready", 32'(d1_ready_o), 1);
    chk("rst1_count", 32'(d1_count), 0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();

    // continuous stream 0x01..0x10
    ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      valid_i = (k < 16);
      din_i = 8'(k + 1);
      tick();
      if (k == 2) chk("lat_before", 32'(valid_o), 0);
      if (k >= 3 && k < 19) begin
        chk("stream_valid", 32'(valid_o), 1);
        chk("stream_data", 32'(dout_o), 32'(k - 2));
      end
      if (k >= 3 && k <= 15) chk("stream_count", 32'(count_o), 4);
      if (k == 19) chk("stream_end_valid", 32'(valid_o), 0);
    end

    // fill with downstream stalled
    ready_i = 1'b0;
    valid_i = 1'b1;
    n = 0;
    for (int c = 0; c < 16; c++) begin
      din_i = 8'(8'h20 + n);
      if (ready_o) n++;
      tick();
    end
    chk("fill_accepted", n, 8);
    chk("fill_ready", 32'(ready_o), 0);
    chk("fill_count", 32'(count_o), 8);
    valid_i = 1'b0;
    ready_i = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (valid_o) begin
        chk("drain_data", 32'(dout_o), 32'(8'h20 + got));
        got++;
      end
      tick();
    end
    chk("drain_got", got, 8);
    chk("drain_count", 32'(count_o), 0);

    // flush at count 5
    ready_i = 1'b0;
    valid_i = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && count_o != 4'd5; c++) begin
      din_i = 8'(8'h40 + n);
      if (ready_o) n++;
      tick();
    end
    chk("preflush_count", 32'(count_o), 5);
    flush = 1'b1;
    din_i = 8'hAA;
    tick();
    flush = 1'b0;
    valid_i = 1'b0;
    chk("flush_valid", 32'(valid_o), 0);
    chk("flush_count", 32'(count_o), 0);
    chk("flush_ready", 32'(ready_o), 1);
    ready_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (valid_o) seen++;
      tick();
    end
    chk("flush_no_output", seen, 0);

    // asynchronous reset at count 6
    ready_i = 1'b0;
    valid_i = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && count_o != 4'd6; c++) begin
      din_i = 8'(8'h60 + n);
      if (ready_o) n++;
      tick();
    end
    chk("prerst_count", 32'(count_o), 6);
    valid_i = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 0);
    chk("arst_dout", 32'(dout_o), 0);
    chk("arst_count", 32'(count_o), 0);
    chk("arst_ready", 32'(ready_o), 1);
    #2 rst = 1'b1;
    ready_i = 1'b1;
    valid_i = 1'b1;
    din_i = 8'h55;
    tick();
    valid_i = 1'b0;
    chk("post_rst_count", 32'(count_o), 1);
    tick();
    tick();
    chk("post_rst_lat", 32'(valid_o), 0);
    tick();
    chk("post_rst_valid", 32'(valid_o), 1);
    chk("post_rst_data", 32'(dout_o), 32'h55);
    tick();
    chk("post_rst_empty", 32'(count_o), 0);

    // random handshakes, 1000 words
    acc = 0;
    d0 = delivered;
    for (int c = 0; c < 10000 && acc < 1000; c++) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = 1'($urandom_range(0, 1));
      din_i = 8'($urandom);
      if (valid_i && ready_o) acc++;
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (20) tick();
    chk("rand_accepted", acc, 1000);
    chk("rand_delivered", delivered - d0, 1000);
    chk("rand_count", 32'(count_o), 0);

    // DEPTH=1 instance
    d1_ready_i = 1'b1;
    d1_valid_i = 1'b1;
    d1_din = 8'h11;
    tick();
    chk("d1_lat_valid", 32'(d1_valid_o), 1);
    chk("d1_lat_data", 32'(d1_dout), 32'h11);
    d1_valid_i = 1'b0;
    tick();
    chk("d1_empty", 32'(d1_valid_o), 0);
    d1_ready_i = 1'b0;
    d1_valid_i = 1'b1;
    d1_din = 8'h21;
    tick();
    chk("d1_cnt1", 32'(d1_count), 1);
    chk("d1_rdy1", 32'(d1_ready_o), 1);
    d1_din = 8'h22;
    tick();
    chk("d1_cnt2", 32'(d1_count), 2);
    chk("d1_rdy2", 32'(d1_ready_o), 0);
    d1_din = 8'h23;
    tick();
    chk("d1_cnt_full", 32'(d1_count), 2);
    chk("d1_hold", 32'(d1_dout), 32'h21);
    d1_valid_i = 1'b0;
    d1_ready_i = 1'b1;
    tick();
    chk("d1_second", 32'(d1_dout), 32'h22);
    chk("d1_cnt_drain", 32'(d1_count), 1);
    tick();
    chk("d1_done", 32'(d1_valid_o), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
